// File: rtl/perf_pkg.sv
// Shared constants for the performance-counter bank: event indices,
// default geometry and the CSR read-port FSM states.
package perf_pkg;

    localparam int NUM_EVT_DEF = 7;
    localparam int CNT_W       = 64;
    localparam int ADDR_W_DEF  = 4;

    localparam int EVT_DCACHE_MISS = 0;
    localparam int EVT_ICACHE_MISS = 1;
    localparam int EVT_COMMIT      = 2;
    localparam int EVT_BR          = 3;
    localparam int EVT_MEM         = 4;
    localparam int EVT_BR_PRE      = 5;
    localparam int EVT_BR_PRE_ERR  = 6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } perf_state_e;

endpackage

// File: rtl/perf_cnt_slice.sv
// One 64-bit free-running event counter. A clear wins over a same-cycle
// increment, so that event is intentionally lost.
module perf_cnt_slice
    import perf_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic             freeze,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && !freeze) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/perf_csr_read.sv
// Performance-counter bank with a single-outstanding CSR read port. A low-half
// read snapshots the full counter so the following high-half read is coherent.
module perf_csr_read
    import perf_pkg::*;
#(
    parameter int NUM_EVT = NUM_EVT_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic              freeze_i,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_req_clr,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [31:0]       rd_resp_data,
    output logic              rd_resp_err
);

    localparam int IDX_W = ADDR_W - 1;

    logic [CNT_W-1:0]   cnt_val [NUM_EVT];
    logic [NUM_EVT-1:0] clr_vec;

    perf_state_e        state_reg;
    logic [CNT_W-1:0]   snap_reg;
    logic [IDX_W-1:0]   snap_idx_reg;
    logic               snap_vld_reg;
    logic               resp_valid_reg;
    logic [31:0]        resp_data_reg;
    logic               resp_err_reg;

    logic [IDX_W-1:0]   req_idx;
    logic               req_hi;
    logic               req_in_range;
    logic               accept;
    logic [CNT_W-1:0]   sel_cnt;
    logic [31:0]        rd_data_next;

    assign req_idx      = rd_req_addr[ADDR_W-1:1];
    assign req_hi       = rd_req_addr[0];
    assign req_in_range = (32'(req_idx) < NUM_EVT);
    assign rd_req_ready = (state_reg == S_IDLE) && !reset;
    assign accept       = rd_req_valid && rd_req_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EVT; gi++) begin : g_cnt
            assign clr_vec[gi] = accept && !req_hi && rd_req_clr && req_in_range
                                 && (32'(req_idx) == gi);
            perf_cnt_slice u_slice (
                .clk    (clk),
                .reset  (reset),
                .inc    (evt_i[gi]),
                .clr    (clr_vec[gi]),
                .freeze (freeze_i),
                .cnt    (cnt_val[gi])
            );
        end
    endgenerate

    // Out-of-range indices fall through to zero.
    always_comb begin
        sel_cnt = '0;
        for (int k = 0; k < NUM_EVT; k++) begin
            if (32'(req_idx) == k) begin
                sel_cnt = cnt_val[k];
            end
        end
    end

    always_comb begin
        rd_data_next = '0;
        if (req_in_range) begin
            if (!req_hi) begin
                rd_data_next = sel_cnt[31:0];
            end else if (snap_vld_reg && (snap_idx_reg == req_idx)) begin
                rd_data_next = snap_reg[63:32];
            end else begin
                rd_data_next = sel_cnt[63:32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            snap_reg       <= '0;
            snap_idx_reg   <= '0;
            snap_vld_reg   <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        state_reg      <= S_RESP;
                        resp_valid_reg <= 1'b1;
                        resp_data_reg  <= rd_data_next;
                        resp_err_reg   <= !req_in_range;
                        if (req_in_range && !req_hi) begin
                            snap_reg     <= sel_cnt;
                            snap_idx_reg <= req_idx;
                            snap_vld_reg <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (rd_resp_ready) begin
                        state_reg      <= S_IDLE;
                        resp_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign rd_resp_valid = resp_valid_reg;
    assign rd_resp_data  = resp_data_reg;
    assign rd_resp_err   = resp_err_reg;

endmodule
